// File: rtl/adc_sample_sequencer_pkg.sv
// rtl/adc_sample_sequencer_pkg.sv - shared state encoding and default widths for the ADC sample sequencer
package adc_sample_sequencer_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int NUM_W_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_TRIG  = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/adc_sample_sequencer_edge_detect.sv
// rtl/adc_sample_sequencer_edge_detect.sv - rise/fall detector for a same-domain level signal
module adc_sample_sequencer_edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic hist;

   // History register. During reset it holds RESET_VAL only while the line agrees,
   // so a line already low when reset is released is not taken as a falling edge.
   always_ff @(posedge clk) begin
      if (reset) hist <= sig & RESET_VAL;
      else       hist <= sig;
   end

   assign rise = sig & ~hist;
   assign fall = hist & ~sig;

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - burst of ADC conversions timed from the end of each reset pulse
module adc_sample_sequencer
   import adc_sample_sequencer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NUM_W = NUM_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reset_in,
   input  logic [CNT_W-1:0] delay_time,
   input  logic [CNT_W-1:0] interval_time,
   input  logic [NUM_W-1:0] num_samples,
   input  logic             adc_done,
   output logic             adc_convst,
   output logic [NUM_W-1:0] sample_index,
   output logic             frame_start,
   output logic             frame_done,
   output logic             overrun
);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] interval_q, interval_n;
   logic [NUM_W-1:0] num_q, num_n;
   logic [NUM_W-1:0] index_n;
   logic             convst_n, start_n, done_n, overrun_n;
   logic             rise, fall;

   adc_sample_sequencer_edge_detect #(.RESET_VAL(1'b1)) u_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (reset_in),
      .rise  (rise),
      .fall  (fall)
   );

   // State and registered outputs; every output is the registered copy of its next value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         interval_q   <= '0;
         num_q        <= '0;
         sample_index <= '0;
         adc_convst   <= 1'b0;
         frame_start  <= 1'b0;
         frame_done   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         interval_q   <= interval_n;
         num_q        <= num_n;
         sample_index <= index_n;
         adc_convst   <= convst_n;
         frame_start  <= start_n;
         frame_done   <= done_n;
         overrun      <= overrun_n;
      end
   end

   // Next state; a rising reset_in mid-frame aborts before anything else is considered,
   // so a coincident adc_done is not counted.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      interval_n = interval_q;
      num_n      = num_q;
      index_n    = sample_index;
      convst_n   = 1'b0;
      start_n    = 1'b0;
      done_n     = 1'b0;
      overrun_n  = 1'b0;
      if (rise && state != S_IDLE && state != S_DONE) begin
         overrun_n = 1'b1;
         state_n   = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (fall) begin
                  cnt_n      = delay_time;
                  interval_n = interval_time;
                  num_n      = num_samples;
                  index_n    = '0;
                  start_n    = 1'b1;
                  state_n    = (num_samples == '0) ? S_DONE : S_DELAY;
               end
            end
            S_DELAY, S_GAP: begin
               if (cnt == '0) begin
                  convst_n = 1'b1;
                  state_n  = S_TRIG;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            S_TRIG: state_n = S_WAIT;
            S_WAIT: begin
               if (adc_done) begin
                  if (sample_index == num_q - NUM_W'(1)) begin
                     state_n = S_DONE;
                  end else begin
                     index_n = sample_index + NUM_W'(1);
                     cnt_n   = (interval_q == '0) ? CNT_W'(1) : interval_q;
                     state_n = S_GAP;
                  end
               end
            end
            S_DONE: begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule
